// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray-code helpers and parameter sanity check shared by the multi-channel write controller
package fifo_pkg;
  localparam int GW = 32;
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  // Callers zero-extend narrower pointers to GW and truncate the result, so one body serves every width.
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic bit params_ok(input int num_ch, input int addr_w, input int afull_lvl);
    return num_ch >= 2 && afull_lvl >= 1 && afull_lvl <= (1 << addr_w);
  endfunction
endpackage

// File: rtl/fifo_wr_chan.sv
// fifo_wr_chan: one channel's write pointer, read-pointer synchroniser and status flags
//   wclk/reset      write clock, async active-low reset
//   req_i           write requested for this channel
//   rptr_gray_i     unsynchronised Gray read pointer
//   ovf_clear_i     clears the sticky overflow flag
//   accept_o        request accepted this cycle
//   slot_o          slot the next write lands in
//   wgray_o         registered Gray write pointer
//   occu_o          registered occupancy
//   full_o/afull_o  full / almost-full, from registers only
//   ovf_o           sticky overflow
module fifo_wr_chan
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = (1 << ADDR_W) - 1
) (
  input  logic              wclk,
  input  logic              reset,
  input  logic              req_i,
  input  logic [ADDR_W:0]   rptr_gray_i,
  input  logic              ovf_clear_i,
  output logic              accept_o,
  output logic [ADDR_W-1:0] slot_o,
  output logic [ADDR_W:0]   wgray_o,
  output logic [ADDR_W:0]   occu_o,
  output logic              full_o,
  output logic              afull_o,
  output logic              ovf_o
);
  // Full when the Gray write pointer equals the read pointer with its top two bits flipped.
  localparam logic [ADDR_W:0] FLIP = (ADDR_W+1)'(3) << (ADDR_W - 1);
  logic [ADDR_W:0] wbin_q, wbin_d, wgray_q, wgray_d, rmeta_q, rsync_q, occu_q, rbin, occ;
  logic ovf_q, ovf_d;
  assign rbin     = (ADDR_W+1)'(gray2bin(GW'(rsync_q)));
  assign occ      = wbin_q - rbin;
  assign full_o   = wgray_q == (rsync_q ^ FLIP);
  assign afull_o  = occ >= (ADDR_W+1)'(AFULL_LVL);
  assign accept_o = req_i & ~full_o;
  assign wbin_d   = accept_o ? wbin_q + (ADDR_W+1)'(1) : wbin_q;
  assign wgray_d  = (ADDR_W+1)'(bin2gray(GW'(wbin_d)));
  // A rejected request sets the flag even when a clear arrives in the same cycle.
  assign ovf_d    = (req_i & full_o) | (ovf_q & ~ovf_clear_i);
  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rmeta_q <= '0;
      rsync_q <= '0;
      occu_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rmeta_q <= rptr_gray_i;
      rsync_q <= rmeta_q;
      occu_q  <= occ;
      ovf_q   <= ovf_d;
    end
  end
  assign slot_o  = wbin_q[ADDR_W-1:0];
  assign wgray_o = wgray_q;
  assign occu_o  = occu_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/fifo_write_mc.sv
// fifo_write_mc: write-side controller for NUM_CH circular queues sharing one {channel, slot} memory
//   wclk/reset     write clock, async active-low reset (release expected synchronous to wclk)
//   write_enable   write request for channel wch; wch >= NUM_CH is ignored
//   wdata          write data, registered into mem_wdata on accept
//   rptr_gray      packed per-channel Gray read pointers from the read domain
//   ovf_clear      per-channel overflow clear
//   waddr/wen      registered memory write address and strobe
//   mem_wdata      registered write data aligned with wen
//   wptr_gray      packed registered Gray write pointers
//   full, almost_full, fifo_occu_in, overflow   per-channel status
module fifo_write_mc
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int NUM_CH    = 4,
  parameter int AFULL_LVL = (1 << ADDR_W) - 1,
  parameter int DATA_W    = 8,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                         wclk,
  input  logic                         reset,
  input  logic                         write_enable,
  input  logic [CH_W-1:0]              wch,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [NUM_CH*(ADDR_W+1)-1:0] rptr_gray,
  input  logic [NUM_CH-1:0]            ovf_clear,
  output logic [CH_W+ADDR_W-1:0]       waddr,
  output logic                         wen,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [NUM_CH*(ADDR_W+1)-1:0] wptr_gray,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            almost_full,
  output logic [NUM_CH*(ADDR_W+1)-1:0] fifo_occu_in,
  output logic [NUM_CH-1:0]            overflow
);
  if (!params_ok(NUM_CH, ADDR_W, AFULL_LVL)) begin : g_bad_params
    $error("fifo_write_mc: need NUM_CH >= 2 and 1 <= AFULL_LVL <= 2**ADDR_W");
  end
  logic [NUM_CH-1:0] req, accept;
  logic [ADDR_W-1:0] slot [NUM_CH];
  logic [ADDR_W-1:0] slot_sel;
  logic [CH_W+ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic wen_q, wen_d;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign req[c] = write_enable && wch == CH_W'(c);
    fifo_wr_chan #(.ADDR_W(ADDR_W), .AFULL_LVL(AFULL_LVL)) u_chan (
      .wclk        (wclk),
      .reset       (reset),
      .req_i       (req[c]),
      .rptr_gray_i (rptr_gray[c*(ADDR_W+1) +: ADDR_W+1]),
      .ovf_clear_i (ovf_clear[c]),
      .accept_o    (accept[c]),
      .slot_o      (slot[c]),
      .wgray_o     (wptr_gray[c*(ADDR_W+1) +: ADDR_W+1]),
      .occu_o      (fifo_occu_in[c*(ADDR_W+1) +: ADDR_W+1]),
      .full_o      (full[c]),
      .afull_o     (almost_full[c]),
      .ovf_o       (overflow[c])
    );
  end
  // At most one channel accepts per cycle, so an OR of gated slots is the mux.
  always_comb begin
    slot_sel = '0;
    for (int i = 0; i < NUM_CH; i++) slot_sel |= accept[i] ? slot[i] : '0;
  end
  assign wen_d   = |accept;
  assign waddr_d = wen_d ? {wch, slot_sel} : waddr_q;
  assign wdata_d = wen_d ? wdata : wdata_q;
  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      waddr_q <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      waddr_q <= waddr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
    end
  end
  assign waddr     = waddr_q;
  assign wen       = wen_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_fifo_write_mc.sv
// tb_fifo_write_mc: directed bench with a queue-level reference model for fifo_write_mc
module tb_fifo_write_mc;
  localparam int NC = 2, D = 4, P = 8, PW = 3, AF = 3;
  logic wclk = 1'b0;
  logic reset;
  logic write_enable = 1'b0;
  logic [0:0] wch = '0;
  logic [7:0] wdata = '0;
  logic [5:0] rptr_gray;
  logic [1:0] ovf_clear = '0;
  logic [2:0] waddr;
  logic wen;
  logic [7:0] mem_wdata;
  logic [5:0] wptr_gray, fifo_occu_in;
  logic [1:0] full, almost_full, overflow;
  int rb[NC];
  int n_cmp = 0, n_bad = 0;
  int m_w[NC], m_s1[NC], m_rs[NC], m_occ[NC];
  bit m_ovf[NC];
  bit m_wen;
  int m_addr;
  logic [7:0] m_data = '0;

  fifo_write_mc #(.ADDR_W(2), .NUM_CH(2), .AFULL_LVL(3), .DATA_W(8)) dut (
    .wclk(wclk), .reset(reset), .write_enable(write_enable), .wch(wch), .wdata(wdata),
    .rptr_gray(rptr_gray), .ovf_clear(ovf_clear), .waddr(waddr), .wen(wen),
    .mem_wdata(mem_wdata), .wptr_gray(wptr_gray), .full(full), .almost_full(almost_full),
    .fifo_occu_in(fifo_occu_in), .overflow(overflow)
  );

  always #5 wclk = ~wclk;

  function automatic int g(int b);
    return b ^ (b >> 1);
  endfunction
  function automatic int fill(int c);
    return (m_w[c] - m_rs[c]) & (P - 1);
  endfunction

  assign rptr_gray = {3'(g(rb[1])), 3'(g(rb[0]))};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each channel is a write count and a read pointer seen two edges late.
  always @(posedge wclk or negedge reset) begin
    int f[NC];
    bit acc;
    if (!reset) begin
      for (int c = 0; c < NC; c++) begin
        m_w[c] = 0; m_s1[c] = 0; m_rs[c] = 0; m_occ[c] = 0; m_ovf[c] = 0;
      end
      m_wen = 0; m_addr = 0; m_data = '0;
    end else begin
      for (int c = 0; c < NC; c++) f[c] = fill(c);
      acc = write_enable && int'(wch) < NC && f[wch] != D;
      for (int c = 0; c < NC; c++) begin
        m_occ[c] = f[c];
        if (write_enable && int'(wch) == c && f[c] == D) m_ovf[c] = 1;
        else if (ovf_clear[c]) m_ovf[c] = 0;
        m_rs[c] = m_s1[c];
        m_s1[c] = rb[c];
      end
      m_wen = acc;
      if (acc) begin
        m_addr = int'(wch) * D + m_w[wch] % D;
        m_data = wdata;
        m_w[wch] = (m_w[wch] + 1) % P;
      end
    end
  end

  always @(negedge wclk) begin
    logic [1:0] ef, ea, eo;
    logic [5:0] ew, eq;
    for (int c = 0; c < NC; c++) begin
      ef[c] = fill(c) == D;
      ea[c] = fill(c) >= AF;
      eo[c] = m_ovf[c];
      ew[c*PW +: PW] = 3'(g(m_w[c]));
      eq[c*PW +: PW] = 3'(m_occ[c]);
    end
    chk("cyc_wen", 32'(wen), 32'(m_wen));
    chk("cyc_waddr", 32'(waddr), 32'(m_addr));
    chk("cyc_wdata", 32'(mem_wdata), 32'(m_data));
    chk("cyc_full", 32'(full), 32'(ef));
    chk("cyc_afull", 32'(almost_full), 32'(ea));
    chk("cyc_wptr", 32'(wptr_gray), 32'(ew));
    chk("cyc_occu", 32'(fifo_occu_in), 32'(eq));
    chk("cyc_ovf", 32'(overflow), 32'(eo));
  end

  task automatic drive(input bit we, input int ch, input logic [1:0] clr);
    write_enable = we;
    wch = 1'(ch);
    ovf_clear = clr;
    wdata = 8'($urandom);
    @(posedge wclk);
    #1;
    write_enable = 1'b0;
    ovf_clear = '0;
  endtask

  task automatic pulse_reset();
    rb[0] = 0;
    rb[1] = 0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    rb[0] = 0;
    rb[1] = 0;
    reset = 1'b0;
    @(posedge wclk);
    #1;
    chk("rst_wen", 32'(wen), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wptr", 32'(wptr_gray), 0);
    chk("rst_full", 32'(full), 0);
    reset = 1'b1;
    // Fill channel 0 and overflow it
    drive(1, 0, 2'b00); chk("s1_waddr1", 32'(waddr), 3'b000); chk("s1_wen1", 32'(wen), 1);
    drive(1, 0, 2'b00); chk("s1_waddr2", 32'(waddr), 3'b001); chk("s1_af2", 32'(almost_full[0]), 0);
    drive(1, 0, 2'b00); chk("s1_waddr3", 32'(waddr), 3'b010); chk("s1_af3", 32'(almost_full[0]), 1);
    chk("s1_full3", 32'(full[0]), 0);
    drive(1, 0, 2'b00); chk("s1_waddr4", 32'(waddr), 3'b011); chk("s1_full4", 32'(full[0]), 1);
    chk("s1_occ4", 32'(fifo_occu_in[2:0]), 3);
    drive(1, 0, 2'b00); chk("s1_wen5", 32'(wen), 0); chk("s1_ovf5", 32'(overflow[0]), 1);
    chk("s1_occ5", 32'(fifo_occu_in[2:0]), 4); chk("s1_hold5", 32'(waddr), 3'b011);
    // Read pointer advances by one
    rb[0] = 1;
    drive(0, 0, 2'b00); chk("s2_full_e1", 32'(full[0]), 1);
    drive(0, 0, 2'b00); chk("s2_full_e2", 32'(full[0]), 0);
    drive(1, 0, 2'b00); chk("s2_waddr", 32'(waddr), 3'b000); chk("s2_wen", 32'(wen), 1);
    chk("s2_full", 32'(full[0]), 1);
    // Overflow clear versus set
    drive(0, 0, 2'b01); chk("s6_clear", 32'(overflow[0]), 0);
    drive(1, 0, 2'b01); chk("s6_setwins", 32'(overflow[0]), 1); chk("s6_wen", 32'(wen), 0);
    drive(0, 0, 2'b01); chk("s6_clear2", 32'(overflow[0]), 0);
    // Alternating channels
    pulse_reset();
    drive(1, 1, 2'b00); chk("s3_a1", 32'(waddr), 3'b100);
    drive(1, 0, 2'b00); chk("s3_a2", 32'(waddr), 3'b000);
    drive(1, 1, 2'b00); chk("s3_a3", 32'(waddr), 3'b101);
    drive(1, 0, 2'b00); chk("s3_a4", 32'(waddr), 3'b001);
    drive(1, 1, 2'b00); chk("s3_a5", 32'(waddr), 3'b110);
    drive(1, 0, 2'b00); chk("s3_a6", 32'(waddr), 3'b010);
    drive(0, 0, 2'b00); chk("s3_occ", 32'(fifo_occu_in), 6'b011011); chk("s3_ovf", 32'(overflow), 0);
    // Wrap-around on channel 1
    pulse_reset();
    drive(1, 1, 2'b00); chk("s4_g1", 32'(wptr_gray[5:3]), 3'b001);
    drive(1, 1, 2'b00); chk("s4_g2", 32'(wptr_gray[5:3]), 3'b011);
    drive(1, 1, 2'b00); chk("s4_g3", 32'(wptr_gray[5:3]), 3'b010);
    drive(1, 1, 2'b00); chk("s4_g4", 32'(wptr_gray[5:3]), 3'b110); chk("s4_full", 32'(full[1]), 1);
    rb[1] = 4;
    drive(0, 0, 2'b00);
    drive(0, 0, 2'b00); chk("s4_rptr", 32'(rptr_gray[5:3]), 3'b110); chk("s4_nfull", 32'(full[1]), 0);
    drive(1, 1, 2'b00); chk("s4_g5", 32'(wptr_gray[5:3]), 3'b111); chk("s4_wrap", 32'(waddr), 3'b100);
    drive(1, 1, 2'b00); chk("s4_g6", 32'(wptr_gray[5:3]), 3'b101);
    drive(1, 1, 2'b00); chk("s4_g7", 32'(wptr_gray[5:3]), 3'b100);
    drive(1, 1, 2'b00); chk("s4_g8", 32'(wptr_gray[5:3]), 3'b000); chk("s4_full2", 32'(full[1]), 1);
    // Reset in the middle of a burst
    pulse_reset();
    drive(1, 0, 2'b00);
    drive(1, 0, 2'b00); chk("s5_pre", 32'(waddr), 3'b001);
    write_enable = 1'b1;
    wch = 1'b0;
    reset = 1'b0;
    #1;
    chk("s5_wen", 32'(wen), 0);
    chk("s5_waddr", 32'(waddr), 0);
    chk("s5_wptr", 32'(wptr_gray), 0);
    chk("s5_occ", 32'(fifo_occu_in), 0);
    chk("s5_flags", 32'({full, almost_full, overflow}), 0);
    #1;
    reset = 1'b1;
    drive(1, 0, 2'b00); chk("s5_first", 32'(waddr), 3'b000); chk("s5_firstwen", 32'(wen), 1);
    drive(0, 0, 2'b00);
    drive(0, 0, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
